rf_wb_ctrl: RTL and testbench
=============================

# rf_wb_ctrl

Write-back controller and hazard scoreboard for the 32-entry register file. It shares the file's single write port between two write-back sources (ALU and load/store unit) with round-robin arbitration. It also tracks which registers have outstanding writes so the issue stage stalls on read-after-write and write-after-write hazards. It sits between decode/issue, the execution units, and the register file's wen/wadd/wdata inputs.

## Interface
- W, 32, data width
- N, 32, number of architectural registers (index width 5)
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- iss_valid  in  1  issue stage presents an instruction
- iss_rd  in  5  destination register of issuing instruction
- iss_rs1  in  5  source register 1
- iss_rs2  in  5  source register 2
- iss_ready  out  1  issue may proceed (combinational)
- alu_valid  in  1  ALU result available
- alu_rd  in  5  ALU destination
- alu_data  in  W  ALU result
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- lsu_valid  in  1  load result available
- lsu_rd  in  5  load destination
- lsu_data  in  W  load data
- lsu_ready  out  1  load result accepted this cycle (combinational)
- rf_wen  out  1  register-file write enable (registered)
- rf_wadd  out  5  register-file write address (registered)
- rf_wdata  out  W  register-file write data (registered)
- busy  out  N  scoreboard, bit i = write to register i outstanding (registered)

## Operation
- Scoreboard: busy[0] is hard-wired to 0.
- iss_ready = !busy[iss_rs1] & !busy[iss_rs2] & !busy[iss_rd]. It does not depend on iss_valid.
- Issue handshake: iss_valid & iss_ready. At that edge, busy[iss_rd] is set if iss_rd != 0.
- Arbiter state is a 1-bit priority pointer prio (0 = ALU, 1 = LSU). Reset value is 0.
- Only ALU valid: grant ALU, prio <= 1.
- Only LSU valid: grant LSU, prio <= 0.
- Both valid: grant the source selected by prio, prio <= the other source.
- Neither valid: no grant, prio holds.
- alu_ready / lsu_ready is high only for the granted source. At most one is high per cycle.
- A granted result is captured at the edge:
  - rf_wen <= (rd != 0), rf_wadd <= rd, rf_wdata <= data.
  - With no grant: rf_wen <= 0. rf_wadd and rf_wdata hold.
- Scoreboard clear: busy[rf_wadd] is cleared at the edge where rf_wen = 1, i.e. the edge the register file commits the write.
- Same register set by issue and cleared by commit at the same edge: set wins, because a new producer exists.
- Write-back to a register whose busy bit is 0 is still written. The scoreboard is unaffected.
- Write-back with rd = 0 is accepted (ready high) but produces rf_wen = 0.
- Sources must hold valid/rd/data until their ready is high. The controller does not buffer.

## Timing
- Reset values: rf_wen = 0, rf_wadd = 0, rf_wdata = 0, busy = 0, prio = 0. iss_ready = 1 after reset.
- Reset asserted mid-operation clears all pending state immediately. In-flight results are discarded.
- Write-back latency: result accepted in cycle T, rf_wen high in cycle T+1, register file updated at the end of T+1.
- Scoreboard release: busy bit low from cycle T+2.
- A dependent instruction issuing in T+2 samples the register file (synchronous read) at the end of T+2 and sees the new value. No forwarding is provided.
- Issue-to-stall: instruction issued at the end of cycle T makes busy[rd] visible in T+1.
- Back-to-back grants are allowed every cycle. rf_wen may stay high continuously.

## Test plan
- Reset: hold nrst low with random inputs.
  - Required: busy = 0, rf_wen = 0, iss_ready = 1.
  - Then release with no activity: outputs remain unchanged.
- Single write-back: issue rd = 5, then alu_valid with rd = 5 and data 0xDEADBEEF in cycle T.
  - Required: alu_ready in T; rf_wen = 1, rf_wadd = 5, rf_wdata = 0xDEADBEEF in T+1; busy[5] = 0 from T+2.
- Contention: alu_valid and lsu_valid held for 4 cycles (rd = 1/2), starting from reset.
  - Required: grants ALU, LSU, ALU, LSU.
  - rf_wadd sequence 1, 2, 1, 2 one cycle later.
- Hazard stall: issue rd = 7. Next, present rs1 = 7.
  - Required: iss_ready = 0 until busy[7] clears.
  - Repeat with rd = 7 again (write-after-write): also stalls.
- Simultaneous set/clear: rf_wen committing rd = 9 in the same cycle as an issue with rd = 9.
  - Required: busy[9] = 1 afterwards.
- x0 and reset mid-flight:
  - lsu_valid with rd = 0 → lsu_ready = 1, rf_wen = 0 next cycle.
  - Assert nrst while busy = 0x0000_0F00 and a grant is pending → busy = 0 and rf_wen = 0 immediately.

Source files
------------

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: round-robin arbitration of ALU/LSU results onto the
// register-file write port, plus the busy scoreboard used for issue stalls.
module rf_wb_ctrl #(
  parameter int W  = 32,
  parameter int N  = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  output logic          iss_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [W-1:0]  alu_data,
  output logic          alu_ready,
  input  logic          lsu_valid,
  input  logic [AW-1:0] lsu_rd,
  input  logic [W-1:0]  lsu_data,
  output logic          lsu_ready,
  output logic          rf_wen,
  output logic [AW-1:0] rf_wadd,
  output logic [W-1:0]  rf_wdata,
  output logic [N-1:0]  busy
);

  logic          prio;
  logic          grant_alu_p0;
  logic          grant_lsu_p0;
  logic          vld_p0;
  logic [AW-1:0] wb_rd_p0;
  logic [W-1:0]  wb_data_p0;
  logic          issue_fire;
  logic [N-1:0]  busy_nxt;

  assign iss_ready = ~busy[iss_rs1] & ~busy[iss_rs2] & ~busy[iss_rd];
  assign alu_ready = grant_alu_p0;
  assign lsu_ready = grant_lsu_p0;

  // Stage p0: arbitration and scoreboard next-state.
  always_comb begin
    grant_alu_p0 = alu_valid & (~lsu_valid | ~prio);
    grant_lsu_p0 = lsu_valid & (~alu_valid | prio);
    vld_p0       = grant_alu_p0 | grant_lsu_p0;
    wb_rd_p0     = grant_lsu_p0 ? lsu_rd   : alu_rd;
    wb_data_p0   = grant_lsu_p0 ? lsu_data : alu_data;
    issue_fire   = iss_valid & iss_ready;
    busy_nxt     = busy;
    if (rf_wen)
      busy_nxt[rf_wadd] = 1'b0;
    // Applied after the clear so a fresh producer keeps the register busy.
    if (issue_fire && (iss_rd != '0))
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Stage p1: register-file write port and scoreboard state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prio     <= 1'b0;
      rf_wen   <= 1'b0;
      rf_wadd  <= '0;
      rf_wdata <= '0;
      busy     <= '0;
    end else begin
      busy <= busy_nxt;
      if (grant_alu_p0)
        prio <= 1'b1;
      else if (grant_lsu_p0)
        prio <= 1'b0;
      rf_wen <= vld_p0 && (wb_rd_p0 != '0);
      if (vld_p0) begin
        rf_wadd  <= wb_rd_p0;
        rf_wdata <= wb_data_p0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: reset, write-back latency, arbitration,
// hazard stalls, set/clear collision, x0 writes and mid-flight reset.
module tb_rf_wb_ctrl;
  logic        clk = 1'b0;
  logic        nrst;
  logic        iss_valid;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_wadd;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  rf_wb_ctrl #(.W(32), .N(32)) dut (
    .clk(clk), .nrst(nrst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_wadd(rf_wadd), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  initial begin
    // Reset with random inputs
    nrst = 0;
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1'($urandom); iss_rd = 5'($urandom); iss_rs1 = 5'($urandom);
      iss_rs2 = 5'($urandom);
      alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
      lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = $urandom;
      tick();
    end
    chk("rst_busy", busy, 0);
    chk("rst_wen", rf_wen, 0);
    chk("rst_iss_ready", iss_ready, 1);
    idle_inputs();
    nrst = 1;
    tick(); tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wen", rf_wen, 0);
    chk("post_rst_wadd", rf_wadd, 0);
    chk("post_rst_wdata", rf_wdata, 0);
    chk("post_rst_iss_ready", iss_ready, 1);

    // Single write-back to r5
    iss_valid = 1; iss_rd = 5;
    #1 chk("wb_iss_ready", iss_ready, 1);
    tick();
    iss_valid = 0; iss_rd = 0;
    chk("wb_busy_set", busy, 32'h0000_0020);
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 chk("wb_alu_ready", alu_ready, 1);
    chk("wb_lsu_ready", lsu_ready, 0);
    tick();
    alu_valid = 0;
    chk("wb_wen", rf_wen, 1);
    chk("wb_wadd", rf_wadd, 5);
    chk("wb_wdata", rf_wdata, 32'hDEADBEEF);
    chk("wb_busy_t1", busy, 32'h0000_0020);
    tick();
    chk("wb_busy_t2", busy, 0);
    chk("wb_wen_t2", rf_wen, 0);

    // Contention from reset: ALU, LSU, ALU, LSU
    nrst = 0; #1 nrst = 1;
    tick();
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB2;
    #1 chk("arb0_alu", alu_ready, 1); chk("arb0_lsu", lsu_ready, 0);
    tick();
    chk("arb1_wadd", rf_wadd, 1); chk("arb1_wdata", rf_wdata, 32'hA1);
    chk("arb1_lsu", lsu_ready, 1); chk("arb1_alu", alu_ready, 0);
    tick();
    chk("arb2_wadd", rf_wadd, 2); chk("arb2_wdata", rf_wdata, 32'hB2);
    chk("arb2_alu", alu_ready, 1);
    tick();
    chk("arb3_wadd", rf_wadd, 1);
    chk("arb3_lsu", lsu_ready, 1); chk("arb3_alu", alu_ready, 0);
    tick();
    alu_valid = 0; lsu_valid = 0;
    chk("arb4_wadd", rf_wadd, 2); chk("arb4_wen", rf_wen, 1);
    chk("arb_busy", busy, 0);

    // RAW stall on r7
    iss_valid = 1; iss_rd = 7; iss_rs1 = 0; iss_rs2 = 0;
    #1 chk("raw_issue_ready", iss_ready, 1);
    tick();
    iss_rd = 8; iss_rs1 = 7;
    #1 chk("raw_stall0", iss_ready, 0);
    tick();
    chk("raw_no_set", busy, 32'h0000_0080);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    #1 chk("raw_alu_ready", alu_ready, 1); chk("raw_stall1", iss_ready, 0);
    tick();
    alu_valid = 0;
    chk("raw_wen", rf_wen, 1); chk("raw_wadd", rf_wadd, 7);
    chk("raw_stall2", iss_ready, 0);
    tick();
    chk("raw_release", iss_ready, 1);
    tick();
    chk("raw_busy8", busy, 32'h0000_0100);

    // WAW stall on r7 (prio now points at LSU)
    iss_rd = 7; iss_rs1 = 0; iss_rs2 = 0;
    #1 chk("waw_first_ready", iss_ready, 1);
    tick();
    chk("waw_busy", busy, 32'h0000_0180);
    chk("waw_stall", iss_ready, 0);
    tick();
    iss_valid = 0; iss_rd = 0;
    chk("waw_busy_hold", busy, 32'h0000_0180);
    alu_valid = 1; alu_rd = 8; alu_data = 32'h88;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h70;
    #1 chk("waw_lsu_first", lsu_ready, 1); chk("waw_alu_wait", alu_ready, 0);
    tick();
    lsu_valid = 0;
    chk("waw_wadd7", rf_wadd, 7);
    chk("waw_alu_next", alu_ready, 1);
    tick();
    alu_valid = 0;
    chk("waw_wadd8", rf_wadd, 8);
    chk("waw_clr7", busy, 32'h0000_0100);
    tick();
    chk("waw_clr8", busy, 0);

    // Issue rd=9 on the same edge that commits r9: set wins
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    iss_valid = 1; iss_rd = 9;
    #1 chk("sc_wen", rf_wen, 1); chk("sc_wadd", rf_wadd, 9);
    chk("sc_ready", iss_ready, 1);
    tick();
    iss_valid = 0;
    chk("sc_busy9", busy, 32'h0000_0200);

    // x0 write-back is accepted but not written
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
    #1 chk("x0_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 0;
    chk("x0_wen", rf_wen, 0);
    chk("x0_busy0", busy, 32'h0000_0200);

    // Build busy = 0xF00, then reset with a grant in flight
    iss_valid = 1;
    iss_rd = 8;  tick();
    iss_rd = 10; tick();
    iss_rd = 11; tick();
    iss_valid = 0; iss_rd = 0;
    chk("mid_busy", busy, 32'h0000_0F00);
    alu_valid = 1; alu_rd = 8; alu_data = 32'hCAFE;
    tick();
    alu_rd = 10; alu_data = 32'hBEEF;
    chk("mid_wen_before", rf_wen, 1);
    chk("mid_busy_before", busy, 32'h0000_0F00);
    #2 nrst = 0;
    #1 chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wen", rf_wen, 0);
    chk("mid_rst_wadd", rf_wadd, 0);
    chk("mid_rst_wdata", rf_wdata, 0);
    chk("mid_rst_ready", iss_ready, 1);
    idle_inputs();
    tick();
    nrst = 1;
    tick();
    chk("mid_discard_wen", rf_wen, 0);
    chk("mid_discard_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
